// File: rtl/game_pkg.sv
// Shared board types: cell codes, packed {row,col} position, default board/fleet sizes.
// Pure declarations; no latency or flow control of its own.
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_t;

  localparam int GRID_DEF  = 10;
  localparam int SHIPS_DEF = 10;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } pos_t;

  function automatic logic on_board(pos_t p, logic [3:0] grid);
    return (p.row < grid) && (p.col < grid);
  endfunction

endpackage

// File: rtl/ship_board_ctl_board_ram.sv
// GRIDxGRID cell store: one sync write port, two comb read ports, off-board reads give EMPTY.
// Write visible the cycle after we; no backpressure, writes to off-board cells are dropped.
module board_ram
  import game_pkg::*;
#(
  parameter int GRID = GRID_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  we,
  input  pos_t  wr_pos,
  input  cell_t wr_dat,
  input  pos_t  rd_a_pos,
  output cell_t rd_a_cell,
  input  pos_t  rd_b_pos,
  output cell_t rd_b_cell
);

  localparam int AW = $clog2(GRID * GRID);

  cell_t cells [GRID*GRID];

  function automatic logic [AW-1:0] idx(pos_t p);
    return AW'(int'(p.row) * GRID + int'(p.col));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GRID * GRID; i++) cells[i] <= EMPTY;
    end else if (clr) begin
      for (int i = 0; i < GRID * GRID; i++) cells[i] <= EMPTY;
    end else if (we && on_board(wr_pos, 4'(GRID))) begin
      cells[idx(wr_pos)] <= wr_dat;
    end
  end

  assign rd_a_cell = on_board(rd_a_pos, 4'(GRID)) ? cells[idx(rd_a_pos)] : EMPTY;
  assign rd_b_cell = on_board(rd_b_pos, 4'(GRID)) ? cells[idx(rd_b_pos)] : EMPTY;

endmodule

// File: rtl/ship_board_ctl.sv
// Own-fleet board: click placement with legality check (ADJ_CHECK_EN adds a 9-cycle neighbour scan), shot answers, counters.
// Click->counts 3 cycles (11 with ADJ_CHECK_EN); shot ack one cycle after accept, shots stall while pick_ship=1.
module ship_board_ctl
  import game_pkg::*;
#(
  parameter int GRID  = GRID_DEF,
  parameter int SHIPS = SHIPS_DEF,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mouse_left,
  input  logic [7:0]       cell_pos,
  input  logic             pick_ship,
  input  logic             clear_board,
  input  logic             in_shot_valid,
  input  logic [7:0]       in_shot_pos,
  output logic             in_shot_ack,
  output logic             in_shot_hit,
  output logic             place_err,
  output logic [CNT_W-1:0] ship_count,
  output logic             all_placed,
  output logic [CNT_W-1:0] ships_left,
  output logic             fleet_sunk,
  input  logic [7:0]       rd_pos,
  output logic [1:0]       rd_cell
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_SHOT} state_t;

  state_t state;
  logic   mouse_q;
  pos_t   pos_q;
  pos_t   chk_pos;
  logic   chk_last;
  logic   chk_bad;
  cell_t  rd_a_cell;
  cell_t  rd_b_cell;
  cell_t  wr_dat;
  logic   ram_we;
  logic   click;
  logic   clr_req;

  assign click   = mouse_left && !mouse_q;
  assign clr_req = (state == S_IDLE) && clear_board;

`ifdef ADJ_CHECK_EN
  logic [3:0] nb_cnt;
  logic       adj_bad;
  logic [3:0] row_off;
  logic [3:0] col_off;
  logic       cell_bad;

  // Offsets are 4-bit two's complement; stepping off row/col 0 wraps to 15, which reads as EMPTY.
  always_comb begin
    row_off = 4'hF;
    col_off = 4'hF;
    if (nb_cnt >= 4'd6)      row_off = 4'd1;
    else if (nb_cnt >= 4'd3) row_off = 4'd0;
    case (nb_cnt)
      4'd1, 4'd4, 4'd7: col_off = 4'd0;
      4'd2, 4'd5, 4'd8: col_off = 4'd1;
      default:          col_off = 4'hF;
    endcase
  end

  assign chk_pos  = '{row: pos_q.row + row_off, col: pos_q.col + col_off};
  assign chk_last = (nb_cnt == 4'd8);
  assign cell_bad = (rd_a_cell == SHIP) || ((nb_cnt == 4'd4) && (rd_a_cell != EMPTY));
  assign chk_bad  = adj_bad || cell_bad || !on_board(pos_q, 4'(GRID));
`else
  assign chk_pos  = pos_q;
  assign chk_last = 1'b1;
  assign chk_bad  = !on_board(pos_q, 4'(GRID)) || (rd_a_cell != EMPTY);
`endif

  assign place_err   = (state == S_CHECK) && chk_last && chk_bad;
  assign in_shot_ack = (state == S_SHOT);
  assign in_shot_hit = (state == S_SHOT) && (rd_a_cell == SHIP);
  assign ram_we      = (state == S_WRITE) ||
                       ((state == S_SHOT) && ((rd_a_cell == SHIP) || (rd_a_cell == EMPTY)));
  assign wr_dat      = (state == S_WRITE) ? SHIP : ((rd_a_cell == SHIP) ? HIT : MISS);
  assign all_placed  = (ship_count == CNT_W'(SHIPS));
  assign fleet_sunk  = all_placed && (ships_left == '0);
  assign rd_cell     = rd_b_cell;

  board_ram #(.GRID(GRID)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_req),
    .we        (ram_we),
    .wr_pos    (pos_q),
    .wr_dat    (wr_dat),
    .rd_a_pos  ((state == S_SHOT) ? pos_q : chk_pos),
    .rd_a_cell (rd_a_cell),
    .rd_b_pos  (pos_t'(rd_pos)),
    .rd_b_cell (rd_b_cell)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mouse_q    <= 1'b0;
      pos_q      <= '0;
      ship_count <= '0;
      ships_left <= '0;
`ifdef ADJ_CHECK_EN
      nb_cnt     <= '0;
      adj_bad    <= 1'b0;
`endif
    end else begin
      mouse_q <= mouse_left;
      case (state)
        S_IDLE: begin
          if (clear_board) begin
            ship_count <= '0;
            ships_left <= '0;
          end else if (click && pick_ship && !all_placed) begin
            pos_q <= pos_t'(cell_pos);
            state <= S_CHECK;
          end else if (in_shot_valid && !pick_ship) begin
            pos_q <= pos_t'(in_shot_pos);
            state <= S_SHOT;
          end
        end
        S_CHECK: begin
          if (chk_last) state <= chk_bad ? S_IDLE : S_WRITE;
`ifdef ADJ_CHECK_EN
          nb_cnt  <= chk_last ? 4'd0 : nb_cnt + 4'd1;
          adj_bad <= chk_last ? 1'b0 : (adj_bad || cell_bad);
`endif
        end
        S_WRITE: begin
          if (!all_placed) begin
            ship_count <= ship_count + 1'b1;
            ships_left <= ships_left + 1'b1;
          end
          state <= S_IDLE;
        end
        S_SHOT: begin
          if (in_shot_hit && (ships_left != '0)) ships_left <= ships_left - 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
